nfu_tile_sequencer: RTL and testbench
=====================================

Name: nfu_tile_sequencer

Overview:
Sequences one layer's worth of Tn-wide input tiles and TnxTn synapse tiles from NBin/SB into the NFU-1 pipeline. Issue order is outer loop over output tiles, inner loop over input tiles. Generates SRAM read addresses and a global pipeline enable. Carries valid/first/last/out-tile tags alongside the data so they emerge aligned with the NFU-1 output register, where the NFU-2 accumulate stage consumes them.

Parameters:
CNT_W, 8, width of tile counts and tile indices
ADDR_W, 16, width of NBin/SB read addresses
PIPE_LAT, 3, cycles from read-enable issue to valid data at the NFU-1 output register (SRAM read 1 + nb_in_reg/sb_reg 1 + nfu1_out_reg 1)

Ports:
clk  in  1  main clock
rst  in  1  synchronous, active-high reset
i_start  in  1  single-cycle layer start request
i_num_in_tiles  in  CNT_W  input tiles per output tile (Ni/Tn); sampled on accepted start
i_num_out_tiles  in  CNT_W  output tiles (No/Tn); sampled on accepted start
i_stall  in  1  downstream back-pressure; freezes sequencer and datapath
o_pipe_en  out  1  enable for nb_in_reg/sb_reg/nfu1_out_reg; equals ~i_stall
o_busy  out  1  high from accepted start until o_done
o_nbin_rd_en  out  1  NBin read strobe
o_nbin_addr  out  ADDR_W  NBin address, equals the input-tile index
o_sb_rd_en  out  1  SB read strobe, identical to o_nbin_rd_en
o_sb_addr  out  ADDR_W  SB address, running count out_tile*num_in + in_tile
o_valid  out  1  NFU-1 output register holds a valid tile
o_first  out  1  with o_valid: first input tile of the current output tile (clear accumulator)
o_last  out  1  with o_valid: last input tile of the current output tile (write to NBout)
o_out_tile  out  CNT_W  output-tile index of the tile currently at the NFU-1 output
o_done  out  1  one-cycle pulse when the final tagged tile has left the pipe

Behaviour:
- Reset: all outputs 0 except o_pipe_en, which is ~i_stall. Counters, tag shift register and FSM are cleared; FSM goes to IDLE.
- Reset mid-layer: everything aborts the same way; no o_done; in-flight tags are discarded.
- FSM has four states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: i_start with both counts nonzero is accepted. Counts are latched, in/out/sb counters zeroed, state goes to ISSUE. A start with either count 0 is ignored and the FSM stays in IDLE.
- ISSUE: while i_stall=0, rd_en is asserted every cycle with the current addresses.
  - Each issue pushes tag {valid=1, first=(in==0), last=(in==num_in-1), out_tile} into stage 0 of a PIPE_LAT-deep shift register.
  - After each issue, in increments and sb_addr increments. When in wraps from num_in-1 to 0, out increments.
  - Issuing the final tile (out==num_out-1, in==num_in-1) moves the FSM to DRAIN.
- DRAIN: rd_en=0 and bubbles (valid=0) shift in. When the final tile's tag reaches the output stage, the FSM goes to DONE.
- DONE: o_done=1 and o_busy=0 for exactly one cycle, then IDLE. The tag pipe is empty at this point.
- Stall: i_stall=1 freezes the FSM, all counters and the tag shift register. rd_en=0 while stalled. o_valid/o_first/o_last/o_out_tile hold their values. A stall arriving in DONE does not extend the o_done pulse.
- i_start while o_busy=1 is ignored; there is no queuing.
- Latency: the tile issued at cycle t with no stalls appears with o_valid=1 at cycle t+PIPE_LAT. Total cycles from accepted start to o_done = num_in*num_out + PIPE_LAT + 1 when unstalled.
- num_in=1: first and last are both 1 on every tile.
- Address widths: o_nbin_addr and o_sb_addr are zero-extended from their counters. sb_addr wraps modulo 2^ADDR_W; software keeps num_in*num_out ≤ 2^ADDR_W.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/ISSUE/DRAIN/DONE)
  - tag record layout {valid, first, last, out_tile}
  - PIPE_LAT default, kept consistent with the NFU-1 pipeline depth
- One sub-module: nfu_tag_pipe, a PIPE_LAT-deep tag shift register with enable and synchronous clear.

Test Plan:
- Basic layer: start with num_in=2, num_out=2, no stall.
  - rd_en high 4 cycles; nbin_addr 0,1,0,1; sb_addr 0,1,2,3.
  - o_valid 4 cycles starting 3 cycles after first rd_en; first/last = 10,01,10,01; o_out_tile 0,0,1,1.
  - o_done one cycle later; start-to-done = 8 cycles.
- Single-tile layer: num_in=1, num_out=3.
  - o_first=o_last=1 on all 3 valid tiles; o_out_tile 0,1,2.
- Zero count: start with num_in=0, num_out=5.
  - o_busy stays 0; no rd_en; no o_done.
- Stall mid-issue: num_in=4, num_out=1; i_stall=1 for 2 cycles after the second issue.
  - rd_en low and addresses frozen during the stall; o_valid sequence unchanged, shifted 2 cycles; o_done at cycle 4+3+1+2 = 10.
- Reset mid-layer: rst asserted in DRAIN.
  - Next cycle: o_valid=0, o_busy=0, no o_done.
  - A fresh start afterwards runs normally from addr 0.
- Start while busy: second i_start during ISSUE with different counts.
  - Ignored; the first layer's counts and addresses are unchanged.

Source files
------------

// File: rtl/nfu_tile_sequencer_pkg.sv
// Shared definitions for the NFU tile sequencer: FSM states, tag flag layout
// and the default NFU-1 pipeline depth.
package nfu_tile_sequencer_pkg;

  // SRAM read (1) + nb_in_reg/sb_reg (1) + nfu1_out_reg (1)
  localparam int unsigned NFU1_PIPE_LAT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Tag record is {valid, first, last, out_tile}; out_tile width follows CNT_W.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_flags_t;

  localparam int unsigned TAG_FLAGS_W = $bits(tag_flags_t);

  function automatic int unsigned tag_width(input int unsigned cnt_w);
    return TAG_FLAGS_W + cnt_w;
  endfunction

endpackage

// File: rtl/nfu_tag_pipe.sv
// DEPTH-stage tag shift register that travels alongside the NFU-1 datapath.
// Shifts only when enabled; synchronous clear empties every stage.
module nfu_tag_pipe #(
  parameter int unsigned W     = 11,
  parameter int unsigned DEPTH = 3
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_tag,
  output logic [W-1:0] o_tag
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d = stage_q;
    if (i_en) begin
      stage_d[0] = i_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign o_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/nfu_tile_sequencer.sv
// Issues one layer of NBin/SB tile reads (outer loop output tiles, inner loop
// input tiles) and carries valid/first/last/out_tile tags aligned to NFU-1 output.
module nfu_tile_sequencer
  import nfu_tile_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned PIPE_LAT = NFU1_PIPE_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_num_in_tiles,
  input  logic [CNT_W-1:0]  i_num_out_tiles,
  input  logic              i_stall,
  output logic              o_pipe_en,
  output logic              o_busy,
  output logic              o_nbin_rd_en,
  output logic [ADDR_W-1:0] o_nbin_addr,
  output logic              o_sb_rd_en,
  output logic [ADDR_W-1:0] o_sb_addr,
  output logic              o_valid,
  output logic              o_first,
  output logic              o_last,
  output logic [CNT_W-1:0]  o_out_tile,
  output logic              o_done
);

  typedef struct packed {
    tag_flags_t       flags;
    logic [CNT_W-1:0] out_tile;
  } tag_t;

  localparam int unsigned      TAG_W   = tag_width(CNT_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  num_in_q, num_in_d;
  logic [CNT_W-1:0]  num_out_q, num_out_d;
  logic [CNT_W-1:0]  in_q, in_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [ADDR_W-1:0] sb_q, sb_d;

  tag_t tag_in, tag_out;
  logic issue, in_last, out_last, final_at_out;

  assign issue    = (state_q == ST_ISSUE) && !i_stall;
  assign in_last  = (in_q == num_in_q - CNT_ONE);
  assign out_last = (out_q == num_out_q - CNT_ONE);
  // Only the layer's final tile carries last with the highest out_tile index.
  assign final_at_out = tag_out.flags.valid && tag_out.flags.last &&
                        (tag_out.out_tile == num_out_q - CNT_ONE);

  always_comb begin
    tag_in = '0;
    if (issue) begin
      tag_in.flags.valid = 1'b1;
      tag_in.flags.first = (in_q == '0);
      tag_in.flags.last  = in_last;
      tag_in.out_tile    = out_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    num_in_d  = num_in_q;
    num_out_d = num_out_q;
    in_d      = in_q;
    out_d     = out_q;
    sb_d      = sb_q;
    if (!i_stall) begin
      case (state_q)
        ST_IDLE: begin
          if (i_start && (i_num_in_tiles != '0) && (i_num_out_tiles != '0)) begin
            num_in_d  = i_num_in_tiles;
            num_out_d = i_num_out_tiles;
            in_d      = '0;
            out_d     = '0;
            sb_d      = '0;
            state_d   = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          sb_d = sb_q + ADDR_W'(1);
          if (in_last) begin
            in_d  = '0;
            out_d = out_q + CNT_ONE;
            if (out_last) state_d = ST_DRAIN;
          end else begin
            in_d = in_q + CNT_ONE;
          end
        end
        ST_DRAIN: if (final_at_out) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end else if (state_q == ST_DONE) begin
      // A stall never stretches the done pulse.
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      num_in_q  <= '0;
      num_out_q <= '0;
      in_q      <= '0;
      out_q     <= '0;
      sb_q      <= '0;
    end else begin
      state_q   <= state_d;
      num_in_q  <= num_in_d;
      num_out_q <= num_out_d;
      in_q      <= in_d;
      out_q     <= out_d;
      sb_q      <= sb_d;
    end
  end

  nfu_tag_pipe #(
    .W     (TAG_W),
    .DEPTH (PIPE_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .i_clr (rst),
    .i_en  (!i_stall),
    .i_tag (tag_in),
    .o_tag (tag_out)
  );

  assign o_pipe_en    = ~i_stall;
  assign o_busy       = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign o_nbin_rd_en = issue && !rst;
  assign o_sb_rd_en   = o_nbin_rd_en;
  assign o_nbin_addr  = ADDR_W'(in_q);
  assign o_sb_addr    = sb_q;
  assign o_valid      = tag_out.flags.valid;
  assign o_first      = tag_out.flags.first;
  assign o_last       = tag_out.flags.last;
  assign o_out_tile   = tag_out.out_tile;
  assign o_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_nfu_tile_sequencer.sv
// Bench for nfu_tile_sequencer: queue/delay-line reference model checked every
// cycle, directed layers pinned to literal timelines, then randomized traffic.
module tb_nfu_tile_sequencer;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned PL     = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 1'b0;
  logic              i_stall = 1'b0;
  logic [CNT_W-1:0]  i_num_in_tiles = '0;
  logic [CNT_W-1:0]  i_num_out_tiles = '0;
  logic              o_pipe_en, o_busy, o_nbin_rd_en, o_sb_rd_en;
  logic [ADDR_W-1:0] o_nbin_addr, o_sb_addr;
  logic              o_valid, o_first, o_last, o_done;
  logic [CNT_W-1:0]  o_out_tile;

  int checks = 0;
  int errors = 0;

  nfu_tile_sequencer #(
    .CNT_W    (CNT_W),
    .ADDR_W   (ADDR_W),
    .PIPE_LAT (PL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_num_in_tiles  (i_num_in_tiles),
    .i_num_out_tiles (i_num_out_tiles),
    .i_stall         (i_stall),
    .o_pipe_en       (o_pipe_en),
    .o_busy          (o_busy),
    .o_nbin_rd_en    (o_nbin_rd_en),
    .o_nbin_addr     (o_nbin_addr),
    .o_sb_rd_en      (o_sb_rd_en),
    .o_sb_addr       (o_sb_addr),
    .o_valid         (o_valid),
    .o_first         (o_first),
    .o_last          (o_last),
    .o_out_tile      (o_out_tile),
    .o_done          (o_done)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] nbin;
    logic [ADDR_W-1:0] sb;
    logic              f;
    logic              l;
    logic [CNT_W-1:0]  ot;
  } item_t;

  typedef struct packed {
    logic  v;
    item_t it;
  } slot_t;

  item_t pend[$];
  slot_t mp [PL];
  int    outstanding = 0;
  bit    m_done = 1'b0;
  bit    m_idle, m_nd, exp_rd;

  always @(negedge clk) begin
    chk("pipe_en", o_pipe_en, !i_stall);
    if (rst) begin
      chk("rd_en_in_reset", o_nbin_rd_en, 0);
    end else begin
      exp_rd = (pend.size() > 0) && !i_stall;
      chk("nbin_rd_en", o_nbin_rd_en, exp_rd);
      chk("sb_rd_en", o_sb_rd_en, exp_rd);
      if (pend.size() > 0) begin
        chk("nbin_addr", o_nbin_addr, pend[0].nbin);
        chk("sb_addr", o_sb_addr, pend[0].sb);
      end
      chk("busy", o_busy, (pend.size() > 0) || (outstanding > 0));
      chk("done", o_done, m_done);
      chk("valid", o_valid, mp[PL-1].v);
      if (mp[PL-1].v) begin
        chk("first", o_first, mp[PL-1].it.f);
        chk("last", o_last, mp[PL-1].it.l);
        chk("out_tile", o_out_tile, mp[PL-1].it.ot);
      end
    end

    // Advance the model across the coming rising edge.
    if (rst) begin
      pend.delete();
      for (int i = 0; i < PL; i++) mp[i] = '0;
      outstanding = 0;
      m_done = 1'b0;
    end else begin
      m_idle = (pend.size() == 0) && (outstanding == 0) && !m_done;
      m_nd = 1'b0;
      if (!i_stall) begin
        if (mp[PL-1].v) begin
          outstanding--;
          if (outstanding == 0) m_nd = 1'b1;
        end
        for (int i = PL-1; i > 0; i--) mp[i] = mp[i-1];
        if (pend.size() > 0) begin
          mp[0].v  = 1'b1;
          mp[0].it = pend.pop_front();
        end else begin
          mp[0] = '0;
        end
        if (m_idle && i_start && i_num_in_tiles != 0 && i_num_out_tiles != 0) begin
          for (int o = 0; o < int'(i_num_out_tiles); o++) begin
            for (int n = 0; n < int'(i_num_in_tiles); n++) begin
              item_t t;
              t.nbin = ADDR_W'(n);
              t.sb   = ADDR_W'(o * int'(i_num_in_tiles) + n);
              t.f    = (n == 0);
              t.l    = (n == int'(i_num_in_tiles) - 1);
              t.ot   = CNT_W'(o);
              pend.push_back(t);
            end
          end
          outstanding = int'(i_num_in_tiles) * int'(i_num_out_tiles);
        end
      end
      m_done = m_nd;
    end
  end

  // ---------------- directed layer runner with per-cycle trace ----------------
  logic [31:0] tr_rd [32], tr_nb [32], tr_sb [32], tr_v [32], tr_f [32];
  logic [31:0] tr_l [32], tr_ot [32], tr_busy [32], tr_done [32];

  task automatic run_layer(input int nin, input int nout, input int stall_from,
                           input int stall_len, input int rst_at, input int restart_at,
                           input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      i_start = (k == 0) || (k == restart_at);
      if (k == restart_at) begin
        i_num_in_tiles  = 3;
        i_num_out_tiles = 3;
      end else begin
        i_num_in_tiles  = CNT_W'(nin);
        i_num_out_tiles = CNT_W'(nout);
      end
      i_stall = (k >= stall_from) && (k < stall_from + stall_len);
      rst     = (k == rst_at);
      @(negedge clk);
      tr_rd[k] = o_nbin_rd_en;  tr_nb[k] = o_nbin_addr;  tr_sb[k] = o_sb_addr;
      tr_v[k]  = o_valid;       tr_f[k]  = o_first;      tr_l[k]  = o_last;
      tr_ot[k] = o_out_tile;    tr_busy[k] = o_busy;     tr_done[k] = o_done;
      @(posedge clk);
      #1;
    end
    i_start = 1'b0;
    i_stall = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic check_2x2(input string p);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("%s rd c%0d", p, k), tr_rd[k], (k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) begin
        chk($sformatf("%s nbin c%0d", p, k), tr_nb[k], (k - 1) % 2);
        chk($sformatf("%s sb c%0d", p, k), tr_sb[k], k - 1);
      end
      chk($sformatf("%s valid c%0d", p, k), tr_v[k], (k >= 4 && k <= 7));
      if (k >= 4 && k <= 7) begin
        chk($sformatf("%s first c%0d", p, k), tr_f[k], ((k - 4) % 2) == 0);
        chk($sformatf("%s last c%0d", p, k), tr_l[k], ((k - 4) % 2) == 1);
        chk($sformatf("%s out_tile c%0d", p, k), tr_ot[k], (k - 4) / 2);
      end
      chk($sformatf("%s done c%0d", p, k), tr_done[k], k == 8);
    end
  endtask

  int cnt;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic 2x2 layer
    run_layer(2, 2, -1, 0, -1, -1, 12);
    check_2x2("basic");

    // Single input tile per output tile
    run_layer(1, 3, -1, 0, -1, -1, 10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("n1 valid c%0d", k), tr_v[k], (k >= 4 && k <= 6));
      if (k >= 4 && k <= 6) begin
        chk($sformatf("n1 first c%0d", k), tr_f[k], 1);
        chk($sformatf("n1 last c%0d", k), tr_l[k], 1);
        chk($sformatf("n1 out_tile c%0d", k), tr_ot[k], k - 4);
      end
      chk($sformatf("n1 done c%0d", k), tr_done[k], k == 7);
    end

    // Zero count is ignored
    run_layer(0, 5, -1, 0, -1, -1, 8);
    cnt = 0;
    for (int k = 0; k < 8; k++) cnt += int'(tr_busy[k]) + int'(tr_rd[k]) + int'(tr_done[k]);
    chk("zero busy/rd/done count", cnt, 0);

    // Two-cycle stall after the second issue
    run_layer(4, 1, 3, 2, -1, -1, 14);
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("stall rd c%0d", k), tr_rd[k], (k == 1 || k == 2 || k == 5 || k == 6));
      chk($sformatf("stall valid c%0d", k), tr_v[k], (k >= 6 && k <= 9));
      chk($sformatf("stall done c%0d", k), tr_done[k], k == 10);
    end
    chk("stall nbin c5", tr_nb[5], 2);
    chk("stall nbin frozen c3", tr_nb[3], 2);
    chk("stall nbin frozen c4", tr_nb[4], 2);
    chk("stall sb c6", tr_sb[6], 3);
    chk("stall first c6", tr_f[6], 1);
    chk("stall last c9", tr_l[9], 1);

    // Reset while draining, then a fresh layer
    run_layer(2, 2, -1, 0, 6, -1, 12);
    chk("rst valid c7", tr_v[7], 0);
    chk("rst busy c7", tr_busy[7], 0);
    cnt = 0;
    for (int k = 7; k < 12; k++) cnt += int'(tr_done[k]) + int'(tr_busy[k]);
    chk("rst no done/busy after abort", cnt, 0);
    run_layer(2, 2, -1, 0, -1, -1, 12);
    check_2x2("after_rst");

    // Start while busy with different counts is ignored
    run_layer(2, 2, -1, 0, -1, 2, 12);
    check_2x2("busy_start");

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst             = ($urandom % 250) == 0;
      i_start         = ($urandom % 6) == 0;
      i_num_in_tiles  = CNT_W'($urandom_range(0, 5));
      i_num_out_tiles = CNT_W'($urandom_range(0, 4));
      i_stall         = ($urandom % 5) == 0;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    i_start = 1'b0;
    i_stall = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("quiesce busy", o_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
